microoperation_sequencer: RTL

MICROOPERATION_SEQUENCER -- requirements
Module: microoperation_sequencer

---
 rtl/microoperation_sequencer_pkg.sv | 25 ++
 rtl/microoperation_sequencer_register_bank.sv | 40 ++++
 rtl/microoperation_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/microoperation_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microoperation_sequencer_pkg
// Description : Shared state encodings, logic-unit op codes and default width
//               for the microoperation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package microoperation_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] OP_AND   = 2'b00;
    localparam logic [1:0] OP_OR    = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam logic [1:0] OP_NOT_A = 2'b11;

endpackage
`default_nettype wire

// File: rtl/microoperation_sequencer_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_4x4
// Description : Four-entry register bank, two asynchronous read ports and one
//               synchronous write port with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_4x4
    import microoperation_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [1:0]              i_waddr,
    input  logic signed [WIDTH-1:0] i_wdata,
    input  logic [1:0]              i_raddr_a,
    input  logic [1:0]              i_raddr_b,
    output logic signed [WIDTH-1:0] o_rdata_a,
    output logic signed [WIDTH-1:0] o_rdata_b
);

    logic signed [WIDTH-1:0] r_mem [4];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/microoperation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : microoperation_sequencer
// Description : Issues one logic-unit microoperation from a 4-entry bank,
//               waits LATENCY cycles and writes the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module microoperation_sequencer
    import microoperation_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op_select,
    input  logic [1:0]              src_a,
    input  logic [1:0]              src_b,
    input  logic [1:0]              dest,
    input  logic                    load_enable,
    input  logic [1:0]              load_address,
    input  logic signed [WIDTH-1:0] load_data,
    output logic [1:0]              selective_set,
    output logic signed [WIDTH-1:0] processor_register,
    output logic signed [WIDTH-1:0] b_in,
    input  logic signed [WIDTH-1:0] data,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result
);

    localparam int                 C_CNT_W      = $clog2(LATENCY + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_RELOAD = C_CNT_W'(LATENCY - 1);

    seq_state_t              r_state;
    seq_state_t              w_next_state;
    logic [C_CNT_W-1:0]      r_wait_cnt;
    logic [1:0]              r_op;
    logic [1:0]              r_src_a;
    logic [1:0]              r_src_b;
    logic [1:0]              r_dest;
    logic signed [WIDTH-1:0] r_result;

    logic                    w_last_wait;
    logic                    w_load;
    logic                    w_we;
    logic [1:0]              w_waddr;
    logic signed [WIDTH-1:0] w_wdata;
    logic signed [WIDTH-1:0] w_rd_a;
    logic signed [WIDTH-1:0] w_rd_b;

    assign w_last_wait = (r_state == ST_WAIT) && (r_wait_cnt == '0);
    assign w_load      = (r_state == ST_IDLE) && load_enable;

    // Loads and write-backs never coincide: loads only in IDLE, write-back only in WAIT.
    assign w_we    = w_load | w_last_wait;
    assign w_waddr = w_last_wait ? r_dest : load_address;
    assign w_wdata = w_last_wait ? data   : load_data;

    register_bank_4x4 #(
        .WIDTH (WIDTH)
    ) u_bank (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_src_a),
        .i_raddr_b (r_src_b),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    always_comb begin
        w_next_state       = r_state;
        busy               = (r_state != ST_IDLE);
        done               = (r_state == ST_DONE);
        processor_register = '0;
        b_in               = '0;
        selective_set      = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state       = ST_WAIT;
                processor_register = w_rd_a;
                b_in               = w_rd_b;
                selective_set      = r_op;
            end
            ST_WAIT: begin
                processor_register = w_rd_a;
                b_in               = w_rd_b;
                selective_set      = r_op;
                if (r_wait_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_op       <= 2'b00;
            r_src_a    <= 2'b00;
            r_src_b    <= 2'b00;
            r_dest     <= 2'b00;
            r_result   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && start) begin
                r_op    <= op_select;
                r_src_a <= src_a;
                r_src_b <= src_b;
                r_dest  <= dest;
            end
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= C_CNT_RELOAD;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_last_wait) begin
                r_result <= data;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire
